// File: rtl/rx_os_lane_counter.sv
// -----------------------------------------------------------------------------
// rx_os_lane_counter
//
// Per-lane ordered-set consistency counter, sitting directly upstream of the
// master RX LTSSM. It watches decoded TS1/TS2 ordered sets from the lane's
// block decoder and counts consecutive ordered sets of the expected type whose
// link number, lane number and rate ID all match the first one seen (the
// reference). The 4-bit count feeds this lane's slice of the master's
// countersValues bus; the master's resetOsCheckers bit clears the block.
//
// Ports:
//   clk              block clock
//   reset            asynchronous, active-low reset
//   clearCounter     synchronous clear (master resetOsCheckers[LANE_ID])
//   laneEnable       lane belongs to the link; 0 holds the block cleared
//   rxElectricalIdle lane electrical idle; 1 acts as a clear
//   osValid          one-cycle pulse, complete ordered set on os* inputs
//   osType           00 other/none, 01 TS1, 10 TS2, 11 reserved
//   osLinkNum        link number field (8'hF7 = PAD)
//   osLaneNum        lane number field (8'hF7 = PAD)
//   osRateId         data-rate identifier symbol
//   expectedType     TS type the current substate requires
//   requiredCount    consecutive matches needed
//   count            consecutive matching ordered sets, saturating
//   countReached     count >= requiredCount and requiredCount != 0
//   capturedLinkNum  link number of the reference ordered set
//   capturedLaneNum  lane number of the reference ordered set
//   capturedRateId   rate ID of the reference ordered set
//   mismatchPulse    one-cycle pulse when a tracked sequence is broken
//   capturedLaneId   static LANE_ID echo, debug only
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no reference ordered set held, count = 0
//   ST_TRACK | reference held, count < requiredCount
//   ST_DONE  | reference held, count >= requiredCount
// -----------------------------------------------------------------------------
module rx_os_lane_counter #(
  parameter int unsigned LANE_ID   = 0,
  parameter int unsigned SAT_COUNT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearCounter,
  input  logic       laneEnable,
  input  logic       rxElectricalIdle,
  input  logic       osValid,
  input  logic [1:0] osType,
  input  logic [7:0] osLinkNum,
  input  logic [7:0] osLaneNum,
  input  logic [7:0] osRateId,
  input  logic [1:0] expectedType,
  input  logic [3:0] requiredCount,
  output logic [3:0] count,
  output logic       countReached,
  output logic [7:0] capturedLinkNum,
  output logic [7:0] capturedLaneNum,
  output logic [7:0] capturedRateId,
  output logic       mismatchPulse,
  output logic [3:0] capturedLaneId
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] SAT = SAT_COUNT[3:0];

  logic [1:0] state;
  logic [1:0] state_d;
  logic [3:0] count_d;
  logic       reached_d;
  logic [7:0] link_d;
  logic [7:0] lane_d;
  logic [7:0] rate_d;
  logic       mismatch_d;

  logic       clear;
  logic       type_match;
  logic       fields_match;
  logic [3:0] count_inc;

  assign capturedLaneId = LANE_ID[3:0];

  // Any of the three clear sources wins over an ordered set in the same cycle.
  assign clear        = clearCounter | rxElectricalIdle | ~laneEnable;
  assign type_match   = (osType == expectedType);
  // PAD (8'hF7) is deliberately compared like any other value.
  assign fields_match = (osLinkNum == capturedLinkNum) &&
                        (osLaneNum == capturedLaneNum) &&
                        (osRateId  == capturedRateId);
  assign count_inc    = (count >= SAT) ? SAT : count + 4'd1;

  function automatic logic [1:0] derive_state(input logic [3:0] c,
                                              input logic [3:0] req);
    if ((req != 4'd0) && (c >= req)) begin
      return ST_DONE;
    end
    return ST_TRACK;
  endfunction

  always_comb begin
    state_d    = state;
    count_d    = count;
    link_d     = capturedLinkNum;
    lane_d     = capturedLaneNum;
    rate_d     = capturedRateId;
    mismatch_d = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      count_d = 4'd0;
      link_d  = 8'h00;
      lane_d  = 8'h00;
      rate_d  = 8'h00;
    end else if (osValid) begin
      case (state)
        ST_IDLE: begin
          if (type_match) begin
            link_d  = osLinkNum;
            lane_d  = osLaneNum;
            rate_d  = osRateId;
            count_d = 4'd1;
            state_d = (requiredCount <= 4'd1) ? ST_DONE : ST_TRACK;
          end
        end
        default: begin
          if (!type_match) begin
            // Wrong type breaks the sequence; the reference fields are kept
            // so debug can still see what was being tracked.
            count_d    = 4'd0;
            mismatch_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (fields_match) begin
            count_d = count_inc;
            state_d = derive_state(count_inc, requiredCount);
          end else begin
            // Same type, different content: this set becomes the new reference.
            link_d     = osLinkNum;
            lane_d     = osLaneNum;
            rate_d     = osRateId;
            count_d    = 4'd1;
            mismatch_d = 1'b1;
            state_d    = derive_state(4'd1, requiredCount);
          end
        end
      endcase
    end
  end

  // countReached is evaluated every edge against the live requiredCount, so a
  // threshold change mid-sequence is reflected one cycle later without
  // disturbing the count itself.
  assign reached_d = (requiredCount != 4'd0) && (count_d >= requiredCount);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      count           <= 4'd0;
      countReached    <= 1'b0;
      capturedLinkNum <= 8'h00;
      capturedLaneNum <= 8'h00;
      capturedRateId  <= 8'h00;
      mismatchPulse   <= 1'b0;
    end else begin
      state           <= state_d;
      count           <= count_d;
      countReached    <= reached_d;
      capturedLinkNum <= link_d;
      capturedLaneNum <= lane_d;
      capturedRateId  <= rate_d;
      mismatchPulse   <= mismatch_d;
    end
  end

endmodule
